// File: rtl/mem_stage_dcache_if.sv
// Main-memory request/ready bus between the MEM-stage data cache and memory.
interface mem_stage_dcache_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  // Cache side: issues requests, receives completion and read data.
  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  // Memory side: accepts requests, signals completion.
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_stage_dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
// One-word lines, zero-cycle read hits, stall during refill or write-through.
module mem_stage_dcache #(
  parameter int unsigned INDEX_BITS    = 4,
  parameter int unsigned MISS_CNT_BITS = 16
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [31:0]              address,
  input  logic [31:0]              writeData,
  input  logic                     MemRead,
  input  logic                     MemWrite,
  output logic [31:0]              readData,
  output logic                     hit,
  output logic                     stall,
  mem_stage_dcache_if.master       memBus,
  output logic [MISS_CNT_BITS-1:0] miss_count
);

  localparam int unsigned LINES    = 1 << INDEX_BITS;
  localparam int unsigned TAG_BITS = 30 - INDEX_BITS;
  localparam logic [MISS_CNT_BITS-1:0] CNT_ONE = MISS_CNT_BITS'(1);

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;

  state_t state, stateNext;

  logic [LINES-1:0]    validQ;
  logic [TAG_BITS-1:0] tagStore  [LINES];
  logic [31:0]         dataStore [LINES];

  logic [INDEX_BITS-1:0] index, fillIndex;
  logic [TAG_BITS-1:0]   tag, fillTag;
  logic                  lookupHit;
  logic                  idleWrite, idleReadMiss, fillNow;
  logic                  unusedAddrBits;

  assign index     = address[INDEX_BITS+1:2];
  assign tag       = address[31:INDEX_BITS+2];
  // Refill targets the line named by the registered request address, since
  // the CPU-side inputs are not sampled while the refill is outstanding.
  assign fillIndex = memBus.mem_addr[INDEX_BITS+1:2];
  assign fillTag   = memBus.mem_addr[31:INDEX_BITS+2];
  assign lookupHit = validQ[index] && (tagStore[index] == tag);

  assign idleWrite    = (state == IDLE) && MemWrite;
  assign idleReadMiss = (state == IDLE) && MemRead && !MemWrite && !lookupHit;
  assign fillNow      = (state == RD_MISS) && memBus.mem_ready;

  assign unusedAddrBits = ^{address[1:0], memBus.mem_addr[1:0]};

  // State register.
  always_ff @(posedge clock) begin
    if (!resetn) state <= IDLE;
    else         state <= stateNext;
  end

  // Next-state: writes take priority over reads in IDLE.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (MemWrite)                  stateNext = WR_THRU;
        else if (MemRead && !lookupHit) stateNext = RD_MISS;
      end
      RD_MISS: if (memBus.mem_ready) stateNext = IDLE;
      WR_THRU: if (memBus.mem_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Pipeline-facing outputs; forced quiet while reset is asserted.
  always_comb begin
    hit      = 1'b0;
    stall    = 1'b0;
    readData = '0;
    if (resetn) begin
      case (state)
        IDLE: begin
          if (MemWrite) begin
            stall = 1'b1;
          end else if (MemRead) begin
            if (lookupHit) begin
              hit      = 1'b1;
              readData = dataStore[index];
            end else begin
              stall = 1'b1;
            end
          end
        end
        default: stall = 1'b1;
      endcase
    end
  end

  // Registered memory request; address and data hold until the next request.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      memBus.mem_req   <= 1'b0;
      memBus.mem_we    <= 1'b0;
      memBus.mem_addr  <= '0;
      memBus.mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MemWrite) begin
            memBus.mem_req   <= 1'b1;
            memBus.mem_we    <= 1'b1;
            memBus.mem_addr  <= {address[31:2], 2'b00};
            memBus.mem_wdata <= writeData;
          end else if (MemRead && !lookupHit) begin
            memBus.mem_req  <= 1'b1;
            memBus.mem_we   <= 1'b0;
            memBus.mem_addr <= {address[31:2], 2'b00};
          end
        end
        RD_MISS: if (memBus.mem_ready) memBus.mem_req <= 1'b0;
        WR_THRU: begin
          if (memBus.mem_ready) begin
            memBus.mem_req <= 1'b0;
            memBus.mem_we  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Saturating read-miss counter.
  always_ff @(posedge clock) begin
    if (!resetn)                           miss_count <= '0;
    else if (idleReadMiss && miss_count != '1) miss_count <= miss_count + CNT_ONE;
  end

  // Valid bits: cleared by reset, set by a completed refill.
  always_ff @(posedge clock) begin
    if (!resetn)      validQ <= '0;
    else if (fillNow) validQ[fillIndex] <= 1'b1;
  end

  // Tag/data arrays: refill overwrites unconditionally; write hits update data.
  always_ff @(posedge clock) begin
    if (resetn) begin
      if (fillNow) begin
        tagStore[fillIndex]  <= fillTag;
        dataStore[fillIndex] <= memBus.mem_rdata;
      end else if (idleWrite && lookupHit) begin
        dataStore[index] <= writeData;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_dcache.sv
// Self-checking bench for mem_stage_dcache: directed table, reset-mid-refill
// sequence and randomized traffic against a line-level cache model.
module tb_mem_stage_dcache;

  localparam int unsigned IB = 4;
  localparam int unsigned CB = 3;

  logic          clock = 1'b0;
  logic          resetn;
  logic [31:0]   address, writeData, readData;
  logic          MemRead, MemWrite, hit, stall;
  logic [CB-1:0] miss_count;

  mem_stage_dcache_if bus();

  mem_stage_dcache #(.INDEX_BITS(IB), .MISS_CNT_BITS(CB)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .address    (address),
    .writeData  (writeData),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .readData   (readData),
    .hit        (hit),
    .stall      (stall),
    .memBus     (bus.master),
    .miss_count (miss_count)
  );

  always #5 clock = ~clock;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Main memory as seen by the responder.
  logic [31:0] mainMem [logic [29:0]];

  function automatic logic [31:0] memVal(input logic [31:0] a);
    if (mainMem.exists(a[31:2])) return mainMem[a[31:2]];
    return {a[31:2], 2'b00} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one CPU access, act as memory, and report what the CPU observed.
  task automatic runOp(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input int unsigned lat,
                       output logic firstHit, output logic [31:0] dataOut,
                       output int unsigned stalls);
    int unsigned cyc;
    bit done;
    MemRead = rd; MemWrite = wr; address = addr; writeData = wd;
    stalls = 0; dataOut = '0;
    @(negedge clock);
    firstHit = hit;
    if (stall) begin
      stalls = 1;
      @(posedge clock); #1;
      done = 0; cyc = 0;
      while (!done) begin
        @(negedge clock);
        if (stall) stalls++;
        chk("memReq", {31'd0, bus.mem_req}, 32'd1);
        chk("memWe", {31'd0, bus.mem_we}, {31'd0, wr});
        chk("memAddr", bus.mem_addr, {addr[31:2], 2'b00});
        if (wr) chk("memWdata", bus.mem_wdata, wd);
        if (cyc >= lat) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = wr ? 32'hBAD0_0BAD : memVal(addr);
          done = 1;
        end
        @(posedge clock); #1;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        cyc++;
      end
      if (wr) mainMem[addr[31:2]] = wd;
      if (rd && !wr) begin
        @(negedge clock);
        if (stall) stalls++;
        chk("hitAfterFill", {31'd0, hit}, 32'd1);
        dataOut = readData;
        @(posedge clock); #1;
      end
    end else begin
      dataOut = readData;
      chk("noReqOnHit", {31'd0, bus.mem_req}, 32'd0);
      @(posedge clock); #1;
    end
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    int unsigned lat;
    logic        expHit;
    logic [31:0] expData;
    int unsigned expStalls;
    int unsigned expMc;
  } vec_t;

  vec_t tbl[10];

  // Line-level cache model for the random phase.
  bit          mValid [16];
  logic [25:0] mTag   [16];
  logic [31:0] mData  [16];
  int unsigned mCount;

  task automatic doReset(input int unsigned cycles);
    resetn = 1'b0;
    repeat (cycles) begin @(posedge clock); #1; end
    resetn = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic fh;
    logic [31:0] dOut;
    int unsigned st;

    resetn = 1'b0; MemRead = 1'b1; MemWrite = 1'b0;
    address = 32'h40; writeData = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    mainMem[32'h40 >> 2]  = 32'hDEAD_BEEF;
    mainMem[32'h440 >> 2] = 32'h0440_F00D;

    // Reset state, with a read held high to show outputs are gated.
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rstHit", {31'd0, hit}, 32'd0);
    chk("rstStall", {31'd0, stall}, 32'd0);
    chk("rstReadData", readData, 32'd0);
    chk("rstMemReq", {31'd0, bus.mem_req}, 32'd0);
    chk("rstMemWe", {31'd0, bus.mem_we}, 32'd0);
    chk("rstMemAddr", bus.mem_addr, 32'd0);
    chk("rstMemWdata", bus.mem_wdata, 32'd0);
    chk("rstMissCount", {29'd0, miss_count}, 32'd0);
    MemRead = 1'b0;
    @(posedge clock); #1;
    resetn = 1'b1;

    tbl[0] = '{1, 0, 32'h40,  0,            3, 0, 32'hDEAD_BEEF, 5, 1};
    tbl[1] = '{1, 0, 32'h40,  0,            0, 1, 32'hDEAD_BEEF, 0, 1};
    tbl[2] = '{0, 1, 32'h40,  32'h1234_5678, 1, 0, 32'h0,        3, 1};
    tbl[3] = '{1, 0, 32'h40,  0,            0, 1, 32'h1234_5678, 0, 1};
    tbl[4] = '{0, 1, 32'h80,  32'hAAAA_5555, 2, 0, 32'h0,        4, 1};
    tbl[5] = '{1, 0, 32'h80,  0,            0, 0, 32'hAAAA_5555, 2, 2};
    tbl[6] = '{1, 0, 32'h440, 0,            1, 0, 32'h0440_F00D, 3, 3};
    tbl[7] = '{1, 0, 32'h40,  0,            2, 0, 32'h1234_5678, 4, 4};
    tbl[8] = '{0, 0, 32'h40,  0,            0, 0, 32'h0,         0, 4};
    tbl[9] = '{1, 1, 32'h43,  32'h0BAD_CAFE, 0, 0, 32'h0,        2, 4};

    for (int i = 0; i < 10; i++) begin
      runOp(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].lat, fh, dOut, st);
      chk($sformatf("tbl%0d.hit", i), {31'd0, fh}, {31'd0, tbl[i].expHit});
      chk($sformatf("tbl%0d.stalls", i), st, tbl[i].expStalls);
      chk($sformatf("tbl%0d.missCount", i), {29'd0, miss_count}, tbl[i].expMc);
      if (tbl[i].rd && !tbl[i].wr)
        chk($sformatf("tbl%0d.readData", i), dOut, tbl[i].expData);
    end
    // Write with MemRead also high went through as a write hit.
    runOp(1, 0, 32'h40, 0, 0, fh, dOut, st);
    chk("wrPrio.hit", {31'd0, fh}, 32'd1);
    chk("wrPrio.data", dOut, 32'h0BAD_CAFE);

    // Reset in the middle of a refill, then a late mem_ready.
    MemRead = 1'b1; address = 32'hC4;
    @(negedge clock);
    chk("midRst.missStall", {31'd0, stall}, 32'd1);
    @(posedge clock); #1;
    @(negedge clock);
    chk("midRst.req", {31'd0, bus.mem_req}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("midRst.stallGated", {31'd0, stall}, 32'd0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("midRst.reqCleared", {31'd0, bus.mem_req}, 32'd0);
    chk("midRst.missCount", {29'd0, miss_count}, 32'd0);
    chk("midRst.stall", {31'd0, stall}, 32'd0);
    MemRead = 1'b0; resetn = 1'b1;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hFFFF_0000;
    @(posedge clock); #1;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    runOp(1, 0, 32'hC4, 0, 1, fh, dOut, st);
    chk("lateReady.noFill", {31'd0, fh}, 32'd0);
    chk("lateReady.stalls", st, 32'd3);
    chk("lateReady.data", dOut, memVal(32'hC4));
    runOp(1, 0, 32'h40, 0, 0, fh, dOut, st);
    chk("afterRst.lineInvalid", {31'd0, fh}, 32'd0);
    chk("afterRst.missCount", {29'd0, miss_count}, 32'd2);

    // Randomized traffic against the model, from a clean reset.
    doReset(2);
    for (int i = 0; i < 16; i++) mValid[i] = 0;
    mCount = 0;
    for (int n = 0; n < 150; n++) begin
      int unsigned kind, lat;
      logic rd, wr, mh;
      logic [31:0] a, wd, expD;
      logic [3:0]  idx;
      logic [25:0] tg;
      kind = $urandom_range(0, 9);
      lat  = $urandom_range(0, 3);
      tg   = 26'($urandom_range(0, 2));
      idx  = 4'($urandom_range(0, 3));
      a    = {tg, idx, 2'($urandom_range(0, 3))};
      wd   = $urandom;
      wr   = (kind >= 7);
      rd   = (kind >= 2 && kind < 7) || (wr && kind == 9);
      mh   = mValid[idx] && (mTag[idx] == tg);
      expD = mh ? mData[idx] : memVal(a);
      runOp(rd, wr, a, wd, lat, fh, dOut, st);
      if (wr) begin
        chk("rnd.wrHit", {31'd0, fh}, 32'd0);
        chk("rnd.wrStalls", st, lat + 2);
        if (mh) mData[idx] = wd;
      end else if (rd) begin
        chk("rnd.rdHit", {31'd0, fh}, {31'd0, mh});
        chk("rnd.rdData", dOut, expD);
        chk("rnd.rdStalls", st, mh ? 0 : lat + 2);
        if (!mh) begin
          mValid[idx] = 1; mTag[idx] = tg; mData[idx] = expD;
          if (mCount < (1 << CB) - 1) mCount++;
        end
      end else begin
        chk("rnd.idleHit", {31'd0, fh}, 32'd0);
        chk("rnd.idleStalls", st, 32'd0);
      end
      chk("rnd.missCount", {29'd0, miss_count}, mCount);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_stage_dcache.md
Name: mem_stage_dcache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache for the MEM stage of the MIPS pipeline.
- Produces the `hit` and `readData` values that are latched into MEM_WB_Register.
- Raises `stall` to freeze the pipeline while a read-miss refill or a write-through transaction is in progress.
- Talks to main memory over a single-outstanding req/ready handshake.

Parameters:
- INDEX_BITS, 4, number of index bits; the cache has 2^INDEX_BITS one-word lines.
- MISS_CNT_BITS, 16, width of the saturating miss counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  synchronous reset, active-low.
- address  in  32  byte address from EX/MEM; bits [1:0] are ignored.
- writeData  in  32  store data from EX/MEM.
- MemRead  in  1  load request.
- MemWrite  in  1  store request.
- readData  out  32  load data; valid when hit=1.
- hit  out  1  read hit in the current cycle.
- stall  out  1  pipeline freeze request.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  1=write, 0=read; registered.
- mem_addr  out  32  word-aligned memory address, registered.
- mem_wdata  out  32  memory write data, registered.
- mem_ready  in  1  memory has completed the request this cycle; for reads, mem_rdata is valid in the same cycle.
- mem_rdata  in  32  memory read data.
- miss_count  out  MISS_CNT_BITS  number of read misses, saturating.

Behaviour:
- Decided interface: one clock; reset is synchronous and active-low (`clock`, `resetn`).
- Address split: index = address[INDEX_BITS+1:2]; tag = address[31:INDEX_BITS+2].
- Each line holds a valid bit, a tag and a 32-bit data word.
- States: IDLE, RD_MISS, WR_THRU.
- Reset (resetn=0 at an edge):
  - State goes to IDLE; all valid bits are cleared.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, miss_count=0.
  - While resetn=0, hit=0, stall=0 and readData=0.
  - Reset also applies in the middle of a transaction: any outstanding request is abandoned and mem_ready is ignored from then on.
- Lookup, combinational, in IDLE only: lookup_hit = valid[index] && (tag_store[index] == tag).
- IDLE, MemRead=1, MemWrite=0:
  - On lookup_hit: hit=1, readData=data[index], stall=0; no state change. Zero-cycle hit.
  - On a miss: hit=0, stall=1. At the edge, go to RD_MISS with mem_req<=1, mem_we<=0, mem_addr<={address[31:2],2'b00}; miss_count increments unless saturated.
- IDLE, MemWrite=1: the write has priority, and MemRead is ignored if also high.
  - stall=1 and hit=0 in this cycle.
  - At the edge, go to WR_THRU with mem_req<=1, mem_we<=1, mem_addr<=word address, mem_wdata<=writeData.
  - If lookup_hit, the line's data is updated to writeData at the same edge.
  - On a miss, the cache is unchanged (no allocate).
- IDLE with neither MemRead nor MemWrite: hit=0, stall=0, no action.
- RD_MISS:
  - stall=1, hit=0.
  - When mem_ready=1: the line is written (valid<=1, tag, data<=mem_rdata), mem_req<=0, and the state returns to IDLE.
  - The CPU holds its inputs while stalled, so the next IDLE cycle hits.
  - Read-miss penalty = memory latency + 2 cycles of stall.
- WR_THRU:
  - stall=1, hit=0.
  - When mem_ready=1: mem_req<=0, mem_we<=0, and the state returns to IDLE. The following IDLE cycle re-evaluates the held inputs.
  - The pipeline must drop MemWrite after stall falls, otherwise the store repeats. The hazard unit guarantees this.
- While in RD_MISS or WR_THRU, MemRead, MemWrite, address and writeData are not sampled.
- mem_ready while mem_req=0 is ignored.
- mem_addr and mem_wdata hold their values until the next request.
- miss_count saturates at all-ones and does not wrap.
- Index aliasing: a refill overwrites the line unconditionally. No writeback is needed, since the cache is write-through.

Test Plan:
1. Reset, then a load of 0x0000_0040 with memory returning 0xDEAD_BEEF after 3 cycles:
   - stall=1 for 5 cycles; one request with mem_addr=0x40, mem_we=0.
   - Then hit=1, readData=0xDEAD_BEEF, stall=0; miss_count=1.
2. Repeat the load of 0x40 on the next access:
   - hit=1 in the same cycle, stall=0, no mem_req, miss_count stays 1.
3. Store 0x1234_5678 to 0x40 (line resident), memory ready after 1 cycle:
   - mem_we=1, mem_wdata=0x1234_5678, stall for 3 cycles.
   - A subsequent load of 0x40 hits with 0x1234_5678.
4. Store to 0x80 (not resident), then load 0x80:
   - The store causes no allocate; the load misses (miss_count increments) and refills from memory.
5. Load 0x0000_0440 (same index as 0x40, different tag):
   - Misses and evicts; a later load of 0x40 misses again.
6. Drive resetn=0 during RD_MISS, before mem_ready:
   - Next cycle: mem_req=0, stall=0, miss_count=0, all lines invalid.
   - A late mem_ready causes no line fill.
